// File: rtl/de2i_150_qsys_spi_shift_if.sv
// Avalon-MM slave bus bundle for the SPI shift block.
// Master drives address/strobes/writedata, slave returns readdata.
interface de2i_150_qsys_spi_shift_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic        read;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output read,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  read,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/de2i_150_qsys_spi_shift.sv
// SPI master (mode 0, MSB first) behind an Avalon-MM slave port.
// cs_in from the upstream PIO gates transfers and drives ss_n.
module de2i_150_qsys_spi_shift #(
    parameter int DATA_W = 8,
    parameter int CLKDIV = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    de2i_150_qsys_spi_shift_if.slave  bus,
    input  logic                      cs_in,
    output logic                      ss_n,
    output logic                      sclk,
    output logic                      mosi,
    input  logic                      miso
);

    localparam int DIV_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int BIT_W = $clog2(DATA_W + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [DATA_W-1:0]   rxdata_q, rxdata_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [BIT_W-1:0]    bitcnt_q, bitcnt_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic                rx_valid_q, rx_valid_d;
    logic                overrun_q, overrun_d;
    logic                collision_q, collision_d;

    logic                wr_stb, rd_stb;
    logic                tx_wr, st_wr, rx_rd;
    logic                half_end, last_bit;
    logic                done, abort;
    logic [DATA_W:0]     shcat;

    assign wr_stb   = bus.chipselect & ~bus.write_n;
    assign rd_stb   = bus.chipselect & bus.read;
    assign tx_wr    = wr_stb & (bus.address == 2'd0);
    assign st_wr    = wr_stb & (bus.address == 2'd1);
    assign rx_rd    = rd_stb & (bus.address == 2'd0);
    assign half_end = (div_q == DIV_W'(CLKDIV - 1));
    assign last_bit = (bitcnt_q == BIT_W'(DATA_W));
    assign abort    = (state_q == SHIFT) & ~cs_in;
    assign done     = (state_q == SHIFT) & cs_in & half_end
                      & sclk_q & last_bit;
    assign shcat    = {shreg_q, miso};

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            rxdata_q    <= '0;
            div_q       <= '0;
            bitcnt_q    <= '0;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            rxdata_q    <= rxdata_d;
            div_q       <= div_d;
            bitcnt_q    <= bitcnt_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            collision_q <= collision_d;
        end
    end

    // Next FSM state: accept a TXDATA write, leave on completion or abort
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (tx_wr && cs_in) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (abort || done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Shifter, divider, serial pins and status flags
    always_comb begin
        shreg_d     = shreg_q;
        rxdata_d    = rxdata_q;
        div_d       = div_q;
        bitcnt_d    = bitcnt_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        rx_valid_d  = rx_valid_q;
        overrun_d   = overrun_q;
        collision_d = collision_q;

        if (state_q == IDLE) begin
            if (tx_wr && cs_in) begin
                shreg_d  = bus.writedata[DATA_W-1:0];
                mosi_d   = bus.writedata[DATA_W-1];
                div_d    = '0;
                bitcnt_d = '0;
                sclk_d   = 1'b0;
            end
        end else if (abort) begin
            sclk_d   = 1'b0;
            mosi_d   = 1'b0;
            div_d    = '0;
            bitcnt_d = '0;
        end else if (half_end) begin
            div_d = '0;
            if (!sclk_q) begin
                // rising edge: sample miso into the LSB
                sclk_d   = 1'b1;
                shreg_d  = shcat[DATA_W-1:0];
                bitcnt_d = bitcnt_q + BIT_W'(1);
            end else begin
                // falling edge: present next bit or finish
                sclk_d = 1'b0;
                if (last_bit) begin
                    rxdata_d = shreg_q;
                    mosi_d   = 1'b0;
                end else begin
                    mosi_d = shreg_q[DATA_W-1];
                end
            end
        end else begin
            div_d = div_q + DIV_W'(1);
        end

        // completion beats a coincident RXDATA read
        if (done) begin
            rx_valid_d = 1'b1;
        end else if (rx_rd) begin
            rx_valid_d = 1'b0;
        end

        if (done && rx_valid_q && !rx_rd) begin
            overrun_d = 1'b1;
        end else if (st_wr && bus.writedata[2]) begin
            overrun_d = 1'b0;
        end

        if (tx_wr && (state_q == SHIFT)) begin
            collision_d = 1'b1;
        end else if (st_wr && bus.writedata[3]) begin
            collision_d = 1'b0;
        end
    end

    // Outputs: pins and combinational read mux
    always_comb begin
        ss_n = ~cs_in;
        sclk = sclk_q;
        mosi = mosi_q;
        bus.readdata = '0;
        unique case (bus.address)
            2'd0: bus.readdata = 32'(rxdata_q);
            2'd1: bus.readdata = {28'b0, collision_q, overrun_q,
                                  rx_valid_q, (state_q == SHIFT)};
            2'd2: bus.readdata = 32'(CLKDIV);
            default: bus.readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_de2i_150_qsys_spi_shift.sv
// Scoreboard bench for the SPI shift block: directed stimulus
// pushes expectations, a negedge monitor pops and compares.
module tb_de2i_150_qsys_spi_shift;

    logic clk;
    logic reset_n;
    logic cs_in;
    logic ss_n;
    logic sclk;
    logic mosi;
    logic miso;
    logic loop_en;
    logic pin_stb;

    int checks;
    int errors;

    logic [31:0] rd_exp_q[$];
    string       rd_name_q[$];
    logic [2:0]  pin_exp_q[$];
    string       pin_name_q[$];

    de2i_150_qsys_spi_shift_if bus ();

    de2i_150_qsys_spi_shift #(
        .DATA_W (8),
        .CLKDIV (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave),
        .cs_in   (cs_in),
        .ss_n    (ss_n),
        .sclk    (sclk),
        .mosi    (mosi),
        .miso    (miso)
    );

    assign miso = loop_en ? mosi : 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare whenever a read strobe or pin probe is presented
    always @(negedge clk) begin
        logic [31:0] e;
        logic [2:0]  p;
        string       n;
        if (bus.chipselect && bus.read) begin
            checks++;
            if (rd_exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: got %h, required none", bus.readdata);
            end else begin
                e = rd_exp_q.pop_front();
                n = rd_name_q.pop_front();
                if (bus.readdata !== e) begin
                    errors++;
                    $display("FAIL %s: got %h, required %h", n, bus.readdata, e);
                end
            end
        end
        if (pin_stb) begin
            checks++;
            if (pin_exp_q.size() == 0) begin
                errors++;
                $display("FAIL pin_unexpected: got %b, required none", {ss_n, sclk, mosi});
            end else begin
                p = pin_exp_q.pop_front();
                n = pin_name_q.pop_front();
                if ({ss_n, sclk, mosi} !== p) begin
                    errors++;
                    $display("FAIL %s: {ss_n,sclk,mosi} got %b, required %b",
                             n, {ss_n, sclk, mosi}, p);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.read       = 1'b0;
        bus.address    = 2'd0;
        bus.writedata  = 32'h0;
        pin_stb        = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = a;
        bus.writedata  = d;
        tick();
        bus_idle();
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [31:0] e,
                            input string n);
        rd_exp_q.push_back(e);
        rd_name_q.push_back(n);
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.address    = a;
        tick();
        bus_idle();
    endtask

    task automatic probe(input logic [1:0] a, input logic [31:0] e,
                         input logic [2:0] p, input string n);
        pin_exp_q.push_back(p);
        pin_name_q.push_back(n);
        pin_stb = 1'b1;
        bus_read(a, e, n);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic       s, m;
        checks  = 0;
        errors  = 0;
        loop_en = 1'b1;
        cs_in   = 1'b0;
        reset_n = 1'b0;
        bus_idle();

        // 1: reset state
        wait_cycles(2);
        probe(2'd1, 32'h0, 3'b100, "reset_status");
        cs_in = 1'b1;
        #1;
        probe(2'd0, 32'h0, 3'b000, "reset_rxdata");
        bus_read(2'd2, 32'h4, "clkdiv_reg");
        bus_read(2'd3, 32'h0, "reserved_reg");
        reset_n = 1'b1;
        tick();

        // 2: loopback 0xA5, cycle-exact sclk/mosi/busy
        d = 8'hA5;
        bus_write(2'd0, 32'(d));
        for (int k = 0; k < 64; k++) begin
            s = 1'((k / 4) % 2);
            m = d[7 - k / 8];
            probe(2'd1, 32'h1, {1'b0, s, m}, $sformatf("shift_k%0d", k));
        end
        bus_read(2'd1, 32'h2, "a5_status_done");
        bus_read(2'd0, 32'hA5, "a5_rxdata");
        bus_read(2'd1, 32'h0, "a5_status_cleared");

        // 3: collision
        bus_write(2'd0, 32'h3C);
        bus_write(2'd0, 32'hFF);
        bus_read(2'd1, 32'h9, "coll_status_busy");
        wait_cycles(62);
        bus_read(2'd1, 32'hA, "coll_status_done");
        bus_read(2'd0, 32'h3C, "coll_rxdata");
        bus_write(2'd1, 32'h8);
        bus_read(2'd1, 32'h0, "coll_cleared");

        // 4: overrun from back-to-back transfers
        bus_write(2'd0, 32'h11);
        wait_cycles(64);
        bus_write(2'd0, 32'h22);
        wait_cycles(64);
        bus_read(2'd1, 32'h6, "ovr_status");
        bus_read(2'd0, 32'h22, "ovr_rxdata");
        bus_write(2'd1, 32'h4);
        bus_read(2'd1, 32'h0, "ovr_cleared");

        // 5: abort by cs_in after 3 rising edges
        bus_write(2'd0, 32'h5A);
        wait_cycles(64);
        bus_write(2'd0, 32'h81);
        wait_cycles(20);
        cs_in = 1'b0;
        #1;
        probe(2'd1, 32'h3, 3'b110, "abort_before");
        probe(2'd1, 32'h2, 3'b100, "abort_after");
        bus_read(2'd0, 32'h5A, "abort_rxdata");
        bus_write(2'd0, 32'h77);
        probe(2'd1, 32'h0, 3'b100, "cs0_write_ignored");
        bus_read(2'd0, 32'h5A, "cs0_rxdata_kept");

        // 6: RXDATA read coincident with completion
        cs_in = 1'b1;
        #1;
        bus_write(2'd0, 32'h96);
        wait_cycles(64);
        bus_write(2'd0, 32'hC3);
        wait_cycles(63);
        bus_read(2'd0, 32'h96, "coinc_old_rx");
        bus_read(2'd1, 32'h2, "coinc_status");
        bus_read(2'd0, 32'hC3, "coinc_new_rx");

        tick();
        checks++;
        if (rd_exp_q.size() != 0 || pin_exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d/%0d pending, required 0/0",
                     rd_exp_q.size(), pin_exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
